// File: rtl/seq_div_32.sv
// ============================================================================
//  seq_div_32 : multi-cycle restoring divider, one quotient bit per clock.
//  result = {remainder, quotient}; signed mode truncates toward zero.
//  Revision 1.0
// ============================================================================
`default_nettype none

module seq_div_32 #(
  parameter int WIDTH  = 32,
  parameter bit SIGNED = 1'b1
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic                 start,
  input  logic [WIDTH-1:0]     dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 busy,
  output logic                 done,
  output logic                 div_by_zero,
  output logic [2*WIDTH-1:0]   result
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_ITER  = 3'd2,
    S_FIX   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [CW-1:0]    cnt;
  logic             q_neg;
  logic             r_neg;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] q_final;
  logic [WIDTH-1:0] r_final;

  // Magnitudes stay unsigned so |MIN| = 2^(W-1) is representable.
  assign a_neg   = SIGNED && a_reg[WIDTH-1];
  assign b_neg   = SIGNED && b_reg[WIDTH-1];
  assign a_abs   = a_neg ? -a_reg : a_reg;
  assign b_abs   = b_neg ? -b_reg : b_reg;
  // Shifted partial remainder minus divisor; MSB set means the trial failed.
  assign trial   = {rem, quo[WIDTH-1]} - {1'b0, b_mag};
  assign q_final = q_neg ? -quo : quo;
  assign r_final = r_neg ? -rem : rem;

  always_ff @(posedge clk) begin
    if (clear) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      result      <= '0;
      cnt         <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      b_mag       <= '0;
      rem         <= '0;
      quo         <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_reg <= dividend;
            b_reg <= divisor;
            busy  <= 1'b1;
            state <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (b_reg == '0) begin
            result      <= {a_reg, {WIDTH{1'b1}}};
            div_by_zero <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b1;
            state       <= S_DONE;
          end else begin
            quo   <= a_abs;
            b_mag <= b_abs;
            rem   <= '0;
            cnt   <= '0;
            q_neg <= a_neg ^ b_neg;
            r_neg <= a_neg;
            state <= S_ITER;
          end
        end
        S_ITER: begin
          if (!trial[WIDTH]) begin
            rem <= trial[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= {rem[WIDTH-2:0], quo[WIDTH-1]};
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            state <= S_FIX;
          end
        end
        S_FIX: begin
          result      <= {r_final, q_final};
          div_by_zero <= 1'b0;
          busy        <= 1'b0;
          done        <= 1'b1;
          state       <= S_DONE;
        end
        S_DONE: begin
          done <= 1'b0;
          if (start) begin
            a_reg <= dividend;
            b_reg <= divisor;
            busy  <= 1'b1;
            state <= S_SETUP;
          end else begin
            state <= S_IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
